macrocell_config_loader: RTL and testbench
==========================================

Name: macrocell_config_loader

Overview:
Serial configuration writer that produces the 13-bit configuration words consumed by each macrocell in a logic array block.
- Accepts a parity-protected serial bitstream through a valid/ready handshake and assembles it into per-macrocell words in shadow storage.
- Commits all words atomically to the configuration outputs only when the whole frame is received without error.
- Sits between the ISP/JTAG programming front end and the array of macrocell models.

Parameters:
MACROCELL_COUNT, 16, number of macrocells configured per frame
CONFIG_WIDTH, 13, configuration bits per macrocell

Ports:
clock  input  1  single clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin a new frame load; honoured in IDLE, DONE, ERROR
abort  input  1  cancel an in-progress load
bit_valid  input  1  bit_in is valid this cycle
bit_in  input  1  serial configuration data
bit_ready  output  1  loader accepts a bit this cycle
configuration  output  MACROCELL_COUNT*CONFIG_WIDTH  committed words; macrocell i at [CONFIG_WIDTH*i+CONFIG_WIDTH-1 : CONFIG_WIDTH*i]
busy  output  1  high in LOAD or CHECK
done  output  1  high in DONE
error  output  1  high in ERROR
word_index  output  clog2(MACROCELL_COUNT)  index of the word currently being received, or the failing word in ERROR

Behaviour:
- Reset (async): state=IDLE; configuration = all ones (erased); shadow storage = all ones; shift register and bit counter = 0; word_index=0; bit_ready, busy, done, error = 0.
- Frame format:
  - MACROCELL_COUNT words, macrocell 0 first.
  - Each word is CONFIG_WIDTH data bits MSB first (bit 12 first), then 1 even-parity bit.
  - Parity rule: the XOR of all 14 bits must be 0.
- A bit transfers on a rising edge where bit_valid & bit_ready. bit_ready is high only in LOAD (registered, state-decoded). bit_in is ignored otherwise.
- IDLE:
  - start=1 -> LOAD; word_index=0, bit counter=0.
- LOAD:
  - Each transfer shifts bit_in into the shift register LSB and increments the bit counter.
  - On the 14th transfer -> CHECK, bit counter cleared.
  - bit_valid low: hold; no timeout.
- CHECK (one cycle, bit_ready=0):
  - Parity good and word_index < MACROCELL_COUNT-1: shadow[word_index] <= data bits; word_index++; -> LOAD.
  - Parity good and word_index = MACROCELL_COUNT-1: final word written; shadow plus final word copied to configuration on this same edge; -> DONE.
  - Parity bad: -> ERROR; word_index holds the failing index; configuration unchanged.
- Minimum frame duration: 15 cycles per word (14 transfers + CHECK). done rises on the edge that leaves the last CHECK.
- DONE / ERROR:
  - Outputs hold.
  - start=1 -> LOAD, clearing word_index, bit counter and error/done.
  - Shadow is not cleared on start; every word is rewritten before any commit.
- abort=1 in LOAD or CHECK -> IDLE; configuration unchanged; partial shadow content discarded logically.
- abort has priority over the CHECK outcome and over a same-cycle bit transfer. abort is ignored in other states.
- start while busy is ignored.
- Reset mid-load returns configuration to all ones immediately (asynchronous).
- configuration changes only on reset or on a successful final CHECK. There is never a partially updated frame.

Test Plan:
- Reset, then idle 5 cycles -> configuration all ones, bit_ready=0, busy=0, done=0, error=0.
- start, send 16 words, word i = 13'h0000+i with correct parity, bit_valid always high -> bit_ready high for 14 cycles then low 1 cycle per word; done rises at cycle 240 after start; configuration[12:0]=0, [207:195]=13'h000F.
- Frame with random bit_valid gaps (about 50% duty) and words 13'h1ABC ^ i -> identical committed result; no bit lost or duplicated.
- Preload all words 13'h0555, then reload with word 5 parity flipped -> error=1, word_index=5, configuration still all 13'h0555; a new start and clean frame -> done=1, error=0.
- abort asserted on the 7th bit of word 9 -> IDLE next edge, bit_ready=0, configuration unchanged; next start then full frame succeeds.
- Assert reset for 1 cycle mid word 3 of a frame following a committed frame -> configuration all ones immediately, state IDLE, start required to resume.

Source files
------------

// File: rtl/macrocell_config_loader.sv
// Serial configuration loader: assembles parity-protected 13-bit macrocell words
// into shadow storage and commits the whole frame atomically after the last word.
module macrocell_config_loader #(
  parameter int MACROCELL_COUNT = 16,
  parameter int CONFIG_WIDTH    = 13,
  localparam int IDX_W = (MACROCELL_COUNT > 1) ? $clog2(MACROCELL_COUNT) : 1
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic                                    abort,
  input  logic                                    bit_valid,
  input  logic                                    bit_in,
  output logic                                    bit_ready,
  output logic [MACROCELL_COUNT*CONFIG_WIDTH-1:0] configuration,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    error,
  output logic [IDX_W-1:0]                        word_index
);

  localparam int FRAME_BITS = CONFIG_WIDTH + 1;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int CFG_W      = MACROCELL_COUNT * CONFIG_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t                  r_state;
  logic [FRAME_BITS-1:0]   r_shift;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [IDX_W-1:0]        r_word_index;
  logic [CFG_W-1:0]        r_shadow;
  logic [CFG_W-1:0]        r_config;
  logic                    r_bit_ready;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_error;

  logic                    w_xfer;
  logic                    w_parity_ok;
  logic                    w_last_word;
  logic                    w_last_bit;
  logic [CONFIG_WIDTH-1:0] w_data;
  logic [CFG_W-1:0]        w_commit;

  assign w_xfer      = bit_valid & r_bit_ready;
  assign w_parity_ok = ~(^r_shift);
  assign w_data      = r_shift[FRAME_BITS-1:1];
  assign w_last_word = (r_word_index == IDX_W'(MACROCELL_COUNT - 1));
  assign w_last_bit  = (r_bit_cnt == CNT_W'(FRAME_BITS - 1));

  // Shadow with the word under check merged in; feeds both shadow and commit.
  always_comb begin
    w_commit = r_shadow;
    w_commit[r_word_index*CONFIG_WIDTH +: CONFIG_WIDTH] = w_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_word_index <= '0;
      r_shadow     <= '1;
      r_config     <= '1;
      r_bit_ready  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_state      <= S_LOAD;
            r_word_index <= '0;
            r_bit_cnt    <= '0;
            r_bit_ready  <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
          end
        end
        S_LOAD: begin
          if (abort) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_bit_ready <= 1'b0;
            r_busy      <= 1'b0;
          end else if (w_xfer) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], bit_in};
            if (w_last_bit) begin
              r_bit_cnt   <= '0;
              r_state     <= S_CHECK;
              r_bit_ready <= 1'b0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (!w_parity_ok) begin
            r_state <= S_ERROR;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else if (w_last_word) begin
            r_shadow <= w_commit;
            r_config <= w_commit;
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_shadow     <= w_commit;
            r_word_index <= r_word_index + 1'b1;
            r_state      <= S_LOAD;
            r_bit_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_bit_ready <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_error     <= 1'b0;
        end
      endcase
    end
  end

  assign bit_ready     = r_bit_ready;
  assign configuration = r_config;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign word_index    = r_word_index;

endmodule

// File: tb/tb_macrocell_config_loader.sv
// Directed bench for macrocell_config_loader: full frames, gapped frames,
// parity error, abort and asynchronous reset mid-load.
module tb_macrocell_config_loader;

  localparam int MC = 16;
  localparam int CW = 13;

  logic            clock;
  logic            reset;
  logic            start;
  logic            abort;
  logic            bit_valid;
  logic            bit_in;
  logic            bit_ready;
  logic [MC*CW-1:0] configuration;
  logic            busy;
  logic            done;
  logic            error;
  logic [3:0]      word_index;

  int n_checks = 0;
  int n_fail   = 0;

  logic [CW-1:0] w_words [MC];
  logic [CW-1:0] exp_cfg [MC];

  macrocell_config_loader #(.MACROCELL_COUNT(MC), .CONFIG_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
    .configuration(configuration), .busy(busy), .done(done),
    .error(error), .word_index(word_index)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives one frame from w_words. Returns early at (stop_word, stop_bit) before that bit.
  task automatic run_frame(input int flip_idx, input bit gaps, input int stop_word,
                           input int stop_bit, output int cyc, output int nrdy,
                           output bit timeout);
    int w = 0;
    int b = 0;
    bit xfer;
    logic [13:0] cur;
    cyc = 0; nrdy = 0; timeout = 0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    while (w < MC) begin
      if (w == stop_word && b == stop_bit) return;
      cur = {w_words[w], (^w_words[w]) ^ (w == flip_idx)};
      bit_valid = gaps ? 1'($urandom_range(1, 0)) : 1'b1;
      bit_in = cur[13-b];
      xfer = bit_valid && bit_ready;
      if (!bit_ready) nrdy++;
      @(posedge clock); #1;
      cyc++;
      if (xfer) begin
        b++;
        if (b == 14) begin b = 0; w++; end
      end
      if (done || error) break;
      if (cyc > 3000) begin timeout = 1; break; end
    end
    bit_valid = 1'b0;
    while (!done && !error && !timeout) begin
      if (!bit_ready) nrdy++;
      @(posedge clock); #1;
      cyc++;
      if (cyc > 3000) timeout = 1;
    end
  endtask

  task automatic check_cfg(input string tag);
    for (int i = 0; i < MC; i++) begin
      n_checks++;
      if (configuration[i*CW +: CW] !== exp_cfg[i]) begin
        n_fail++;
        $display("FAIL %s word %0d: got %h expected %h", tag, i,
                 configuration[i*CW +: CW], exp_cfg[i]);
      end
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; abort = 0; bit_valid = 0; bit_in = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    for (int i = 0; i < MC; i++) exp_cfg[i] = '1;
    check_cfg("reset_cfg");
    check_bit("reset_bit_ready", bit_ready, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    check_bit("reset_error", error, 1'b0);
  endtask

  task automatic test_full_frame();
    int cyc, nrdy; bit to;
    for (int i = 0; i < MC; i++) w_words[i] = 13'(i);
    run_frame(-1, 0, -1, -1, cyc, nrdy, to);
    check_bit("full_timeout", to, 1'b0);
    n_checks++;
    if (cyc != 240) begin n_fail++; $display("FAIL full_done_cycle: got %0d expected 240", cyc); end
    n_checks++;
    if (nrdy != 16) begin n_fail++; $display("FAIL full_notready_cycles: got %0d expected 16", nrdy); end
    check_bit("full_done", done, 1'b1);
    check_bit("full_busy", busy, 1'b0);
    n_checks++;
    if (configuration[12:0] !== 13'h0000 || configuration[207:195] !== 13'h000F) begin
      n_fail++;
      $display("FAIL full_ends: got %h/%h expected 0000/000f", configuration[12:0], configuration[207:195]);
    end
    for (int i = 0; i < MC; i++) exp_cfg[i] = w_words[i];
    check_cfg("full_cfg");
  endtask

  task automatic test_gaps();
    int cyc, nrdy; bit to;
    for (int i = 0; i < MC; i++) w_words[i] = 13'h1ABC ^ 13'(i);
    run_frame(-1, 1, -1, -1, cyc, nrdy, to);
    check_bit("gaps_timeout", to, 1'b0);
    check_bit("gaps_done", done, 1'b1);
    n_checks++;
    if (nrdy != 16) begin n_fail++; $display("FAIL gaps_notready_cycles: got %0d expected 16", nrdy); end
    for (int i = 0; i < MC; i++) exp_cfg[i] = 13'h1ABC ^ 13'(i);
    check_cfg("gaps_cfg");
  endtask

  task automatic test_parity_error();
    int cyc, nrdy; bit to;
    for (int i = 0; i < MC; i++) w_words[i] = 13'h0555;
    run_frame(-1, 0, -1, -1, cyc, nrdy, to);
    check_bit("preload_done", done, 1'b1);
    for (int i = 0; i < MC; i++) exp_cfg[i] = 13'h0555;
    check_cfg("preload_cfg");
    for (int i = 0; i < MC; i++) w_words[i] = 13'h0AAA;
    run_frame(5, 0, -1, -1, cyc, nrdy, to);
    check_bit("perr_timeout", to, 1'b0);
    check_bit("perr_error", error, 1'b1);
    check_bit("perr_done", done, 1'b0);
    n_checks++;
    if (word_index !== 4'd5) begin n_fail++; $display("FAIL perr_word_index: got %0d expected 5", word_index); end
    check_cfg("perr_cfg_kept");
    run_frame(-1, 0, -1, -1, cyc, nrdy, to);
    check_bit("perr_retry_done", done, 1'b1);
    check_bit("perr_retry_error", error, 1'b0);
    for (int i = 0; i < MC; i++) exp_cfg[i] = 13'h0AAA;
    check_cfg("perr_retry_cfg");
  endtask

  task automatic test_abort();
    int cyc, nrdy; bit to;
    for (int i = 0; i < MC; i++) w_words[i] = 13'h1F00 | 13'(i);
    run_frame(-1, 0, 9, 6, cyc, nrdy, to);
    check_bit("abort_pre_ready", bit_ready, 1'b1);
    abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0; bit_valid = 1'b0;
    check_bit("abort_bit_ready", bit_ready, 1'b0);
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_done", done, 1'b0);
    check_cfg("abort_cfg_kept");
    // abort outside LOAD/CHECK is a no-op
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check_bit("abort_idle_busy", busy, 1'b0);
    run_frame(-1, 0, -1, -1, cyc, nrdy, to);
    check_bit("abort_retry_done", done, 1'b1);
    for (int i = 0; i < MC; i++) exp_cfg[i] = 13'h1F00 | 13'(i);
    check_cfg("abort_retry_cfg");
  endtask

  task automatic test_reset_midload();
    int cyc, nrdy; bit to;
    for (int i = 0; i < MC; i++) w_words[i] = 13'h0123 + 13'(i);
    run_frame(-1, 0, 3, 4, cyc, nrdy, to);
    check_bit("rst_pre_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    for (int i = 0; i < MC; i++) exp_cfg[i] = '1;
    check_cfg("rst_async_cfg");
    check_bit("rst_async_busy", busy, 1'b0);
    check_bit("rst_async_ready", bit_ready, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0; bit_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    bit_valid = 1'b0;
    check_bit("rst_idle_busy", busy, 1'b0);
    check_bit("rst_idle_ready", bit_ready, 1'b0);
    run_frame(-1, 0, -1, -1, cyc, nrdy, to);
    check_bit("rst_resume_done", done, 1'b1);
    for (int i = 0; i < MC; i++) exp_cfg[i] = 13'h0123 + 13'(i);
    check_cfg("rst_resume_cfg");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gaps();
    test_parity_error();
    test_abort();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
